// File: rtl/grf_wb_arbiter_pkg.sv
// grf_wb_arbiter_pkg: shared types for the GRF writeback arbiter.
package grf_wb_arbiter_pkg;
    localparam int GRF_ADDR_W = 5;
    typedef struct packed {
        logic [GRF_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic [31:0]           pc;
    } md_entry_t;
endpackage

// File: rtl/md_result_fifo.sv
// md_result_fifo: buffers mult/div results and exposes per-entry valid/addr for hazard lookup.
module md_result_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  md_entry_t                            push_entry,
    output md_entry_t                            head,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH-1:0]                     ent_valid,
    output logic [DEPTH-1:0][GRF_ADDR_W-1:0]     ent_addr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    md_entry_t         mem_q [DEPTH];
    md_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d, off;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    always_comb begin
        full    = cnt_q == CW'(DEPTH);
        empty   = cnt_q == '0;
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        head    = mem_q[rd_q];
        mem_d   = mem_q;
        if (push_ok) mem_d[wr_q] = push_entry;
        wr_d  = push_ok ? wr_q + PW'(1) : wr_q;
        rd_d  = pop_ok ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        off   = '0;
        // An entry is live when its distance from the read pointer is below the count.
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_q;
            ent_valid[i] = {1'b0, off} < cnt_q;
            ent_addr[i]  = mem_q[i].addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between the W stage (priority) and buffered mult/div results.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_we,
    input  logic [GRF_ADDR_W-1:0] wb_addr,
    input  logic [31:0]           wb_data,
    input  logic [31:0]           wb_pc,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [GRF_ADDR_W-1:0] md_addr,
    input  logic [31:0]           md_data,
    input  logic [31:0]           md_pc,
    output logic                  grf_we,
    output logic [GRF_ADDR_W-1:0] grf_addr,
    output logic [31:0]           grf_data,
    output logic [31:0]           grf_pc,
    output logic                  stall_o,
    input  logic [GRF_ADDR_W-1:0] q_addr1,
    input  logic [GRF_ADDR_W-1:0] q_addr2,
    output logic                  q_hit1,
    output logic                  q_hit2,
    output logic                  md_pending
);
    localparam logic [3:0] SL  = 4'(STARVE_LIMIT);
    localparam logic [3:0] SL1 = 4'(STARVE_LIMIT - 1);

    md_entry_t                        head;
    logic                             full, empty, push, grant_md;
    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0][GRF_ADDR_W-1:0] ent_addr;
    logic [3:0]                       starve_q, starve_d;
    logic                             stall_q, stall_d;

    md_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (grant_md),
        .push_entry ('{addr: md_addr, data: md_data, pc: md_pc}),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr)
    );

    always_comb begin
        md_ready   = !full;
        md_pending = !empty;
        stall_o    = stall_q;
        // $0 results complete the handshake but are never buffered.
        push       = md_valid && !full && (md_addr != '0);
        grant_md   = !wb_we && !empty;
        grf_we     = wb_we || grant_md;
        grf_addr   = wb_we ? wb_addr : grant_md ? head.addr : '0;
        grf_data   = wb_we ? wb_data : grant_md ? head.data : '0;
        grf_pc     = wb_we ? wb_pc   : grant_md ? head.pc   : '0;
        starve_d   = (empty || grant_md) ? '0 : (starve_q < SL) ? starve_q + 4'd1 : starve_q;
        stall_d    = grant_md ? 1'b0 : (!empty && starve_q == SL1) ? 1'b1 : stall_q;
        q_hit1     = 1'b0;
        q_hit2     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q_hit1 = q_hit1 | (ent_valid[i] && ent_addr[i] == q_addr1 && q_addr1 != '0);
            q_hit2 = q_hit2 | (ent_valid[i] && ent_addr[i] == q_addr2 && q_addr2 != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed scoreboard bench for the GRF writeback arbiter.
module tb_grf_wb_arbiter;
    import grf_wb_arbiter_pkg::*;
    localparam int DEPTH = 2;

    logic        clk = 0, reset = 1;
    logic        wb_we = 0, md_valid = 0, md_ready, grf_we, stall_o, q_hit1, q_hit2, md_pending;
    logic [4:0]  wb_addr = 0, md_addr = 0, grf_addr, q_addr1 = 0, q_addr2 = 0;
    logic [31:0] wb_data = 0, wb_pc = 0, md_data = 0, md_pc = 0, grf_data, grf_pc;
    int          total = 0, bad = 0;
    md_entry_t   sb[$];

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc), .stall_o(stall_o),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2), .md_pending(md_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        md_valid = 1; md_addr = a; md_data = d; md_pc = p;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        wb_we = we; wb_addr = a; wb_data = d; wb_pc = p;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
    task automatic tick();
        md_entry_t e;
        bit        acc;
        @(negedge clk);
        e = wb_we ? '{addr: wb_addr, data: wb_data, pc: wb_pc} : (sb.size() != 0) ? sb[0] : '0;
        chk("grf_we", 32'(grf_we), 32'(wb_we || sb.size() != 0));
        chk("grf_addr", 32'(grf_addr), 32'(e.addr));
        chk("grf_data", grf_data, e.data);
        chk("grf_pc", grf_pc, e.pc);
        chk("md_ready", 32'(md_ready), 32'(sb.size() < DEPTH));
        chk("md_pending", 32'(md_pending), 32'(sb.size() != 0));
        acc = md_valid && sb.size() < DEPTH && md_addr != 0;
        @(posedge clk);
        if (reset) sb.delete();
        else begin
            if (!wb_we && sb.size() != 0) void'(sb.pop_front());
            if (acc) sb.push_back('{addr: md_addr, data: md_data, pc: md_pc});
        end
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        q_addr1 = 5; q_addr2 = 0;
        #1 chk("rst_stall", 32'(stall_o), 0);
        chk("rst_hit1", 32'(q_hit1), 0);
        tick();
        // md only
        md(8, 32'h1234, 32'h3000);
        tick();
        md_valid = 0; q_addr1 = 8; q_addr2 = 3;
        #1 chk("md_hit1", 32'(q_hit1), 1);
        chk("md_hit2", 32'(q_hit2), 0);
        tick();
        tick();
        // collision: wb holds the port while $9 waits
        md(9, 32'hAA, 32'h3004); wb(1, 5, 32'h55, 32'h4000);
        tick();
        md_valid = 0; q_addr1 = 9; q_addr2 = 9;
        repeat (2) begin
            #1 chk("col_hit1", 32'(q_hit1), 1);
            chk("col_hit2", 32'(q_hit2), 1);
            tick();
        end
        wb_we = 0;
        #1 chk("col_hit_pop", 32'(q_hit1), 1);
        tick();
        #1 chk("col_hit_after", 32'(q_hit1), 0);
        chk("col_stall", 32'(stall_o), 0);
        // full: third result refused, then FIFO-order drain
        wb(1, 2, 32'h22, 32'h4004);
        md(10, 32'h1010, 32'h3010); tick();
        md(11, 32'h1111, 32'h3014); tick();
        md(12, 32'h1212, 32'h3018);
        #1 chk("full_ready", 32'(md_ready), 0);
        tick();
        md_valid = 0; wb_we = 0;
        repeat (3) tick();
        // starvation
        md(7, 32'h77, 32'h3020); tick();
        md_valid = 0; wb(1, 4, 32'h44, 32'h4008);
        repeat (4) begin
            #1 chk("starve_low", 32'(stall_o), 0);
            tick();
        end
        #1 chk("starve_high", 32'(stall_o), 1);
        wb_we = 0;
        tick();
        #1 chk("starve_clear", 32'(stall_o), 0);
        // $0 handling
        md(0, 32'hBAD, 32'h3030); q_addr1 = 0;
        tick();
        md_valid = 0;
        #1 chk("z_pending", 32'(md_pending), 0);
        chk("z_hit", 32'(q_hit1), 0);
        tick();
        wb(1, 0, 32'hDEAD, 32'h400C);
        tick();
        // reset with buffered entries, and reset coinciding with a handshake
        md(3, 32'h33, 32'h3040); tick();
        md(4, 32'h44, 32'h3044); tick();
        md_valid = 0; reset = 1;
        tick();
        reset = 0; wb_we = 0;
        #1 chk("rst2_pending", 32'(md_pending), 0);
        chk("rst2_stall", 32'(stall_o), 0);
        tick();
        md(6, 32'h66, 32'h3050); reset = 1;
        tick();
        md_valid = 0; reset = 0;
        #1 chk("rst3_pending", 32'(md_pending), 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Shares the single GRF write port between two writeback sources: the pipeline W stage and the multi-cycle mult/div unit. The W stage has fixed priority and is never backpressured. Mult/div results are buffered in a small FIFO and drained into idle write slots. A starvation counter requests a pipeline bubble, and pending-target lookups feed the hazard unit.

Parameters:
DEPTH, 2, mult/div result FIFO entries (power of 2, ≥2)
STARVE_LIMIT, 4, cycles a FIFO head may wait ungranted before stall_o asserts (1..15)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
wb_we  in  1  W-stage write request
wb_addr  in  5  W-stage destination register
wb_data  in  32  W-stage write data
wb_pc  in  32  PC of the W-stage instruction
md_valid  in  1  mult/div result valid
md_ready  out  1  FIFO can accept (= !full, from registered count)
md_addr  in  5  mult/div destination register
md_data  in  32  mult/div result
md_pc  in  32  PC of the originating mult/div instruction
grf_we  out  1  write enable to GRF
grf_addr  out  5  write address to GRF
grf_data  out  32  write data to GRF
grf_pc  out  32  PC forwarded to GRF for the write log
stall_o  out  1  registered bubble request to the pipeline
q_addr1  in  5  hazard query address 1
q_addr2  in  5  hazard query address 2
q_hit1  out  1  a buffered entry targets q_addr1 (never for $0)
q_hit2  out  1  a buffered entry targets q_addr2 (never for $0)
md_pending  out  1  FIFO non-empty

Behaviour:
- Reset: FIFO empty, rd/wr pointers 0, starve counter 0, stall_o=0. md_ready=1 and md_pending=0 in the cycle after reset. grf_we=0 unless wb_we=1.
- Accept: md_valid & md_ready at posedge pushes {addr,data,pc}. md_valid with md_addr==0 is accepted (handshake completes) but not pushed; count and pointers are unchanged.
- Grant, combinational mux with zero added latency on the W path:
  - if wb_we: grf_* = wb_*, grf_we=1, FIFO head held;
  - else if FIFO non-empty: grf_* = head, grf_we=1, head popped at posedge;
  - else grf_we=0, grf_addr/data/pc=0.
- wb_we with wb_addr==0 passes through unchanged; GRF ignores the $0 write but logs it.
- No bypass: an md result reaches the GRF at the earliest 1 cycle after acceptance.
- Simultaneous push and pop in one cycle is allowed when not full; count is unchanged. When full, md_ready=0, so no push-with-pop occurs.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.
- Starve counter:
  - increments each cycle the FIFO is non-empty and the head is not granted;
  - clears on a pop or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- stall_o is a register, set at the posedge where counter==STARVE_LIMIT-1 and the head is not granted. It clears at the posedge the head is popped.
- Pipeline contract: wb_we=0 in every cycle stall_o=1. If violated, wb still wins, stall_o stays high and the counter stays saturated.
- q_hit: OR over all valid FIFO entries of (entry.addr==q_addr && q_addr!=0). This is combinational and includes the head being popped this cycle.
- Reset mid-operation drops all buffered entries. Reset in the same cycle as an md handshake drops that result.

Decomposition:
- Shared package holds the md entry struct {addr[4:0], data[31:0], pc[31:0]} and GRF_ADDR_W=5.
- One sub-module, md_result_fifo: storage, pointers, count, full/empty and per-entry valid and address for hit compare.
- Arbitration, the starve counter and the q_hit compare stay in the top.

Test Plan:
- Reset then idle: grf_we=0, md_ready=1, stall_o=0, q_hit1=0.
- Only md: push {addr=8, data=0x1234, pc=0x3000}; next cycle grf_we=1, addr=8, data=0x1234, pc=0x3000; following cycle md_pending=0.
- Collision: push md $9=0xAA, wb_we held 1 with $5=0x55 for 3 cycles. Each of those cycles writes $5; $9 is written on the first wb_we=0 cycle. q_hit1=1 for q_addr1=9 until the pop.
- Full: 2 pushes with wb_we=1 continuously: md_ready=0 and a third md_valid is not accepted. After wb_we drops, entries drain in FIFO order.
- Starvation (STARVE_LIMIT=4): buffered head, wb_we=1 for 4 cycles: stall_o rises after the 4th. Bench drops wb_we, head is written, stall_o clears the next cycle.
- $0 handling: md to $0 completes the handshake with md_pending=0 and no GRF write. wb to $0 gives grf_we=1, grf_addr=0. Reset asserted with 2 entries buffered gives empty FIFO and stall_o=0 on the next cycle.
